// File: rtl/axi_interconnect_width_convert_bresp_merge.sv
// Merges the B responses of the sub-bursts of one split write burst into a single slave-side B response.
// Latency: s_bvalid is registered and rises the cycle after the final sub-burst B handshake.
// Backpressure: m_bready is high only while collecting; s_bready low holds the response and stalls collection; a full request FIFO drops req_ready.
module axi_interconnect_width_convert_bresp_merge #(
  parameter int    WIDTH_ID          = 4,
  parameter int    WIDTH_BUSER       = 1,
  parameter int    WIDTH_OUTSTANDING = 4,
  parameter int    WIDTH_SPLIT       = 4,
  parameter string MERGE_MODE        = "WORST",
  parameter int    U_DLY             = 1,
  localparam int   IW                = (WIDTH_ID == 0) ? 1 : WIDTH_ID,
  localparam int   UW                = (WIDTH_BUSER == 0) ? 1 : WIDTH_BUSER
) (
  input  logic                       clk_sys,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [WIDTH_SPLIT-1:0]     req_num,
  input  logic [IW-1:0]              m_bid,
  input  logic [1:0]                 m_bresp,
  input  logic [UW-1:0]              m_buser,
  input  logic                       m_bvalid,
  output logic                       m_bready,
  output logic [IW-1:0]              s_bid,
  output logic [1:0]                 s_bresp,
  output logic [UW-1:0]              s_buser,
  output logic                       s_bvalid,
  input  logic                       s_bready,
  output logic                       id_err,
  output logic [WIDTH_OUTSTANDING:0] outst_cnt
);
  // U_DLY only matters to behavioural models of this block; the RTL has no assignment delays.
  localparam int  DEPTH     = 1 << WIDTH_OUTSTANDING;
  localparam bit  LAST_MODE = (MERGE_MODE == "LAST");

  typedef enum logic [1:0] {IDLE, COLLECT, SEND} state_t;

  state_t                       state_q, state_d;
  logic [WIDTH_SPLIT-1:0]       fifo_mem_q [DEPTH];
  logic [WIDTH_OUTSTANDING-1:0] wr_ptr_q, rd_ptr_q;
  logic [WIDTH_OUTSTANDING:0]   cnt_q;
  logic [WIDTH_SPLIT-1:0]       beat_cnt_q, beat_cnt_d;
  logic                         first_q, first_d;
  logic [IW-1:0]                id_q, id_d;
  logic [1:0]                   resp_q, resp_d;
  logic [UW-1:0]                user_q, user_d;
  logic                         s_bvalid_q, s_bvalid_d;
  logic                         id_err_q, id_err_d;
  logic                         full, empty, push, pop;

  // Severity order of AXI responses: EXOKAY < OKAY < SLVERR < DECERR.
  function automatic logic [1:0] sev(input logic [1:0] r);
    case (r)
      2'b01:   sev = 2'd0;
      2'b00:   sev = 2'd1;
      2'b10:   sev = 2'd2;
      default: sev = 2'd3;
    endcase
  endfunction

  // The count MSB is set only at exactly DEPTH entries.
  assign full      = cnt_q[WIDTH_OUTSTANDING];
  assign empty     = (cnt_q == '0);
  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign req_ready = !full || pop;
  assign push      = req_valid && req_ready;

  assign m_bready  = (state_q == COLLECT);
  assign s_bvalid  = s_bvalid_q;
  assign s_bid     = id_q;
  assign s_bresp   = resp_q;
  assign s_buser   = user_q;
  assign id_err    = id_err_q;
  assign outst_cnt = cnt_q;

  // Request storage; the data array needs no reset because the pointers gate it.
  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem_q[wr_ptr_q] <= req_num;
  end

  // Request FIFO pointers and occupancy.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Next state: collect sub-responses of the head request, then present the merged one.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    first_d    = first_q;
    id_d       = id_q;
    resp_d     = resp_q;
    user_d     = user_q;
    s_bvalid_d = s_bvalid_q;
    id_err_d   = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) pop = 1'b1;
      end
      COLLECT: begin
        if (m_bvalid && m_bready) begin
          first_d = 1'b0;
          if (first_q) begin
            id_d   = m_bid;
            resp_d = m_bresp;
            user_d = m_buser;
          end else begin
            id_err_d = (m_bid != id_q);
            if (LAST_MODE) begin
              resp_d = m_bresp;
              user_d = m_buser;
            end else begin
              resp_d = (sev(m_bresp) > sev(resp_q)) ? m_bresp : resp_q;
              user_d = user_q | m_buser;
            end
          end
          if (beat_cnt_q == '0) begin
            state_d    = SEND;
            s_bvalid_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q - 1'b1;
          end
        end
      end
      SEND: begin
        if (s_bvalid_q && s_bready) begin
          s_bvalid_d = 1'b0;
          if (!empty) pop = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Popping a request starts a fresh collection without an idle bubble.
    if (pop) begin
      state_d    = COLLECT;
      beat_cnt_d = fifo_mem_q[rd_ptr_q];
      first_d    = 1'b1;
      resp_d     = '0;
      user_d     = '0;
    end
  end

  // FSM and merged-response registers.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      first_q    <= 1'b0;
      id_q       <= '0;
      resp_q     <= '0;
      user_q     <= '0;
      s_bvalid_q <= 1'b0;
      id_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      first_q    <= first_d;
      id_q       <= id_d;
      resp_q     <= resp_d;
      user_q     <= user_d;
      s_bvalid_q <= s_bvalid_d;
      id_err_q   <= id_err_d;
    end
  end

endmodule

// File: tb/tb_axi_interconnect_width_convert_bresp_merge.sv
// Bench for axi_interconnect_width_convert_bresp_merge: WORST and LAST instances share stimulus.
// Table of merge vectors plus directed sequences for full FIFO, backpressure and mid-burst reset.
// Inputs change 1 ns after the rising edge; outputs are read at that same point.
module tb_axi_interconnect_width_convert_bresp_merge;
  logic       clk_sys = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [3:0] req_num = '0;
  logic [3:0] m_bid = '0;
  logic [1:0] m_bresp = '0;
  logic [1:0] m_buser = '0;
  logic       m_bvalid = 1'b0;
  logic       s_bready = 1'b1;

  logic       req_ready_w, m_bready_w, s_bvalid_w, id_err_w;
  logic [3:0] s_bid_w;
  logic [1:0] s_bresp_w, s_buser_w;
  logic [4:0] outst_cnt_w;
  logic       req_ready_l, m_bready_l, s_bvalid_l, id_err_l;
  logic [3:0] s_bid_l;
  logic [1:0] s_bresp_l, s_buser_l;
  logic [4:0] outst_cnt_l;

  int n_chk = 0;
  int n_pass = 0;
  int sb_tot = 0;
  int ie_tot = 0;

  always #5 clk_sys = ~clk_sys;

  axi_interconnect_width_convert_bresp_merge #(.WIDTH_BUSER(2), .MERGE_MODE("WORST")) u_worst (
    .clk_sys(clk_sys), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_w), .req_num(req_num),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_buser(m_buser), .m_bvalid(m_bvalid), .m_bready(m_bready_w),
    .s_bid(s_bid_w), .s_bresp(s_bresp_w), .s_buser(s_buser_w), .s_bvalid(s_bvalid_w), .s_bready(s_bready),
    .id_err(id_err_w), .outst_cnt(outst_cnt_w));

  axi_interconnect_width_convert_bresp_merge #(.WIDTH_BUSER(2), .MERGE_MODE("LAST")) u_last (
    .clk_sys(clk_sys), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_l), .req_num(req_num),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_buser(m_buser), .m_bvalid(m_bvalid), .m_bready(m_bready_l),
    .s_bid(s_bid_l), .s_bresp(s_bresp_l), .s_buser(s_buser_l), .s_bvalid(s_bvalid_l), .s_bready(s_bready),
    .id_err(id_err_l), .outst_cnt(outst_cnt_l));

  // Running totals of slave-side handshakes and id_err pulses on the WORST instance.
  always @(negedge clk_sys) begin
    if (s_bvalid_w && s_bready) sb_tot++;
    if (id_err_w) ie_tot++;
  end

  typedef struct packed {
    logic [3:0]      num;
    logic [0:3][3:0] id;
    logic [0:3][1:0] resp;
    logic [0:3][1:0] user;
    logic [3:0]      e_bid;
    logic [1:0]      e_worst;
    logic [1:0]      e_last;
    logic [1:0]      e_uw;
    logic [1:0]      e_ul;
    int              e_iderr;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic [3:0] n);
    req_valid = 1'b1;
    req_num   = n;
    tick();
    req_valid = 1'b0;
  endtask

  // Presents one beat, waits (bounded) for m_bready, then completes the handshake edge.
  task automatic send_beat(input logic [3:0] id, input logic [1:0] resp, input logic [1:0] user);
    int t;
    t = 0;
    m_bvalid = 1'b1;
    m_bid    = id;
    m_bresp  = resp;
    m_buser  = user;
    while (!m_bready_w && t < 50) begin
      tick();
      t++;
    end
    chk("beat_accepted", m_bready_w, 1);
    tick();
    m_bvalid = 1'b0;
  endtask

  initial begin
    int sb0, ie0, t;
    //         num    ids                          resps                          users                          bid    worst  last   uw     ul   iderr
    vecs[0] = '{4'd3, {4'd5, 4'd5, 4'd5, 4'd5}, {2'b00, 2'b10, 2'b00, 2'b00}, {2'd0, 2'd1, 2'd0, 2'd2}, 4'd5, 2'b10, 2'b00, 2'd3, 2'd2, 0};
    vecs[1] = '{4'd1, {4'd7, 4'd7, 4'd0, 4'd0}, {2'b11, 2'b00, 2'b00, 2'b00}, {2'd1, 2'd0, 2'd0, 2'd0}, 4'd7, 2'b11, 2'b00, 2'd1, 2'd0, 0};
    vecs[2] = '{4'd1, {4'd2, 4'd3, 4'd0, 4'd0}, {2'b00, 2'b00, 2'b00, 2'b00}, {2'd0, 2'd0, 2'd0, 2'd0}, 4'd2, 2'b00, 2'b00, 2'd0, 2'd0, 1};
    vecs[3] = '{4'd0, {4'd9, 4'd0, 4'd0, 4'd0}, {2'b01, 2'b00, 2'b00, 2'b00}, {2'd2, 2'd0, 2'd0, 2'd0}, 4'd9, 2'b01, 2'b01, 2'd2, 2'd2, 0};
    vecs[4] = '{4'd2, {4'hA, 4'hA, 4'hA, 4'd0}, {2'b01, 2'b01, 2'b01, 2'b00}, {2'd0, 2'd0, 2'd1, 2'd0}, 4'hA, 2'b01, 2'b01, 2'd1, 2'd1, 0};
    vecs[5] = '{4'd2, {4'd8, 4'd8, 4'd8, 4'd0}, {2'b01, 2'b00, 2'b01, 2'b00}, {2'd2, 2'd0, 2'd0, 2'd0}, 4'd8, 2'b00, 2'b01, 2'd2, 2'd0, 0};
    vecs[6] = '{4'd2, {4'd1, 4'd4, 4'd6, 4'd0}, {2'b10, 2'b11, 2'b00, 2'b00}, {2'd1, 2'd2, 2'd0, 2'd0}, 4'd1, 2'b11, 2'b00, 2'd3, 2'd0, 2};

    // Reset state.
    rst = 1'b1;
    tick(); tick(); tick();
    chk("rst_s_bvalid", s_bvalid_w, 0);
    chk("rst_s_bid", s_bid_w, 0);
    chk("rst_s_bresp", s_bresp_w, 0);
    chk("rst_m_bready", m_bready_w, 0);
    chk("rst_outst_cnt", outst_cnt_w, 0);
    chk("rst_id_err", id_err_w, 0);
    rst = 1'b0;
    chk("rst_req_ready", req_ready_w, 1);
    tick();

    // Table-driven merge vectors.
    for (int v = 0; v < NV; v++) begin
      sb0 = sb_tot;
      ie0 = ie_tot;
      push(vecs[v].num);
      for (int b = 0; b <= int'(vecs[v].num); b++)
        send_beat(vecs[v].id[b], vecs[v].resp[b], vecs[v].user[b]);
      chk($sformatf("v%0d_s_bvalid_latency", v), s_bvalid_w, 1);
      chk($sformatf("v%0d_s_bid", v), s_bid_w, vecs[v].e_bid);
      chk($sformatf("v%0d_bresp_worst", v), s_bresp_w, vecs[v].e_worst);
      chk($sformatf("v%0d_bresp_last", v), s_bresp_l, vecs[v].e_last);
      chk($sformatf("v%0d_buser_worst", v), s_buser_w, vecs[v].e_uw);
      chk($sformatf("v%0d_buser_last", v), s_buser_l, vecs[v].e_ul);
      chk($sformatf("v%0d_bid_last", v), s_bid_l, vecs[v].e_bid);
      tick(); tick();
      chk($sformatf("v%0d_sb_count", v), sb_tot - sb0, 1);
      chk($sformatf("v%0d_id_err_pulses", v), ie_tot - ie0, vecs[v].e_iderr);
    end

    // Fill the FIFO: the first request is popped into COLLECT, 16 more queue up.
    sb0 = sb_tot;
    req_valid = 1'b1;
    req_num   = 4'd0;
    for (int i = 0; i < 17; i++) tick();
    chk("full_req_ready", req_ready_w, 0);
    chk("full_outst_cnt", outst_cnt_w, 16);
    tick();
    chk("full_push_ignored", outst_cnt_w, 16);
    req_valid = 1'b0;
    send_beat(4'd0, 2'b00, 2'd0);
    chk("full_send_valid", s_bvalid_w, 1);
    chk("full_pushpop_ready", req_ready_w, 1);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("full_pushpop_cnt", outst_cnt_w, 16);
    chk("full_direct_collect", m_bready_w, 1);
    // Drain with a continuously valid master B channel.
    m_bvalid = 1'b1;
    m_bid    = 4'd0;
    m_bresp  = 2'b00;
    m_buser  = 2'd0;
    t = 0;
    while (sb_tot - sb0 < 18 && t < 400) begin
      tick();
      t++;
    end
    tick(); tick(); tick();
    chk("drain_sb_count", sb_tot - sb0, 18);
    chk("drain_outst_cnt", outst_cnt_w, 0);
    chk("empty_no_accept", m_bready_w, 0);
    chk("empty_no_send", s_bvalid_w, 0);
    m_bvalid = 1'b0;
    tick();

    // Slave backpressure: response held, next beat not consumed, direct COLLECT on release.
    sb0 = sb_tot;
    s_bready = 1'b0;
    push(4'd0);
    push(4'd0);
    send_beat(4'd3, 2'b10, 2'd1);
    m_bvalid = 1'b1;
    m_bid    = 4'd4;
    m_bresp  = 2'b11;
    m_buser  = 2'd2;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_s_bvalid", i), s_bvalid_w, 1);
      chk($sformatf("bp%0d_s_bid", i), s_bid_w, 3);
      chk($sformatf("bp%0d_s_bresp", i), s_bresp_w, 2'b10);
      chk($sformatf("bp%0d_m_bready", i), m_bready_w, 0);
      tick();
    end
    chk("bp_queue_kept", outst_cnt_w, 1);
    s_bready = 1'b1;
    tick();
    chk("bp_release_collect", m_bready_w, 1);
    chk("bp_release_s_bvalid", s_bvalid_w, 0);
    chk("bp_release_cnt", outst_cnt_w, 0);
    tick();
    m_bvalid = 1'b0;
    chk("bp_next_s_bvalid", s_bvalid_w, 1);
    chk("bp_next_s_bid", s_bid_w, 4);
    chk("bp_next_s_bresp", s_bresp_w, 2'b11);
    tick();
    chk("bp_sb_count", sb_tot - sb0, 2);

    // Reset in the middle of a collection with requests still queued.
    push(4'd3);
    push(4'd3);
    push(4'd3);
    send_beat(4'd5, 2'b11, 2'd3);
    chk("mid_collect_active", m_bready_w, 1);
    chk("mid_collect_cnt", outst_cnt_w, 2);
    rst = 1'b1;
    tick();
    chk("mrst_s_bvalid", s_bvalid_w, 0);
    chk("mrst_s_bid", s_bid_w, 0);
    chk("mrst_s_bresp", s_bresp_w, 0);
    chk("mrst_s_buser", s_buser_w, 0);
    chk("mrst_m_bready", m_bready_w, 0);
    chk("mrst_id_err", id_err_w, 0);
    chk("mrst_outst_cnt", outst_cnt_w, 0);
    rst = 1'b0;
    chk("mrst_req_ready", req_ready_w, 1);
    tick();
    chk("post_rst_idle", m_bready_w, 0);
    chk("post_rst_empty", outst_cnt_w, 0);
    push(4'd0);
    send_beat(4'd6, 2'b01, 2'd1);
    chk("post_rst_s_bvalid", s_bvalid_w, 1);
    chk("post_rst_s_bid", s_bid_w, 6);
    chk("post_rst_s_bresp", s_bresp_w, 2'b01);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
